// File: rtl/alu_pkg.sv
// Shared opcode constants, ALU latency and in-flight tracking types for the
// ALU issue controller.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NAND = 4'd6;
    localparam logic [3:0] OP_SGT  = 4'd7;
    localparam logic [3:0] OP_IDLE = 4'd15;

    // Fixed number of cycles between driving the ALU and sampling its result.
    localparam int ALU_LAT = 2;

    // One slot of the in-flight shift register.
    typedef struct packed {
        logic       valid;
        logic [3:0] opcode;
        logic [3:0] tag;
    } flight_t;

    // The ALU only produces a meaningful carry for add and subtract.
    function automatic logic carry_meaningful(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_sync_fifo.sv
// Synchronous FIFO with occupancy count. Push while full is honoured only if
// a pop happens in the same cycle; pop while empty is ignored.
module alu_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Qualify push/pop against occupancy and advance pointers and count.
    always_comb begin
        // NOTE: every signal written here is assigned on every path, so no latch is inferred.
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
        pop_data = mem_q[rd_ptr_q];
        count    = count_q;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the count guarantees stale entries are never observed.
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller for an external fixed-latency pipelined ALU: queues
// commands, issues them under response-FIFO credit, tracks them in flight
// and queues the results for the downstream consumer in acceptance order.
module alu_issue_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [4:0]       cmd_shift,
    input  logic [3:0]       cmd_tag,
    output logic [3:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_input1,
    output logic [WIDTH-1:0] alu_input2,
    output logic [4:0]       alu_shiftValue,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic [3:0]       rsp_tag
);
    import alu_pkg::*;

    localparam int CMD_W = 4 + 2 * WIDTH + 5 + 4;
    localparam int RSP_W = WIDTH + 1 + 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             ready_en_q, ready_en_d;
    logic             cmd_push, issue;
    logic [CMD_W-1:0] cmd_push_data, cmd_head;
    logic [CW-1:0]    cmd_count;
    logic [3:0]       head_opcode, head_tag;
    logic [WIDTH-1:0] head_a, head_b;
    logic [4:0]       head_shift;
    logic [CW-1:0]    inflight;
    logic             credit_ok;
    flight_t          flight_q [ALU_LAT];
    flight_t          flight_d [ALU_LAT];
    logic             rsp_push, rsp_pop;
    logic [RSP_W-1:0] rsp_push_data, rsp_head;
    logic [CW-1:0]    rsp_count;

    alu_sync_fifo #(.WIDTH(CMD_W), .DEPTH(DEPTH)) u_cmd_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (cmd_push),
        .push_data (cmd_push_data),
        .pop       (issue),
        .pop_data  (cmd_head),
        .count     (cmd_count)
    );

    alu_sync_fifo #(.WIDTH(RSP_W), .DEPTH(DEPTH)) u_rsp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (rsp_push),
        .push_data (rsp_push_data),
        .pop       (rsp_pop),
        .pop_data  (rsp_head),
        .count     (rsp_count)
    );

    // Command acceptance: ready only once out of reset and while the queue has room.
    always_comb begin
        ready_en_d    = 1'b1;
        cmd_ready     = ready_en_q && (cmd_count != CW'(DEPTH));
        cmd_push      = cmd_valid && cmd_ready;
        cmd_push_data = {cmd_opcode, cmd_a, cmd_b, cmd_shift, cmd_tag};
    end

    // Issue the queue head when every outstanding result has a reserved response slot.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < ALU_LAT; i++) begin
            inflight = inflight + CW'(flight_q[i].valid);
        end
        credit_ok = ({1'b0, rsp_count} + {1'b0, inflight}) < (CW + 1)'(DEPTH);
        {head_opcode, head_a, head_b, head_shift, head_tag} = cmd_head;
        issue          = (cmd_count != '0) && credit_ok;
        alu_opcode     = OP_IDLE;
        alu_input1     = '0;
        alu_input2     = '0;
        alu_shiftValue = '0;
        if (issue) begin
            alu_opcode     = head_opcode;
            alu_input1     = head_a;
            alu_input2     = head_b;
            alu_shiftValue = head_shift;
        end
    end

    // Advance the in-flight tracker; the last stage captures the ALU output.
    always_comb begin
        flight_d[0] = '{valid: issue, opcode: head_opcode, tag: head_tag};
        for (int i = 1; i < ALU_LAT; i++) begin
            flight_d[i] = flight_q[i-1];
        end
        rsp_push      = flight_q[ALU_LAT-1].valid;
        rsp_push_data = {alu_result,
                         carry_meaningful(flight_q[ALU_LAT-1].opcode) && alu_carry,
                         flight_q[ALU_LAT-1].tag};
    end

    // Response presentation; payload held at zero while nothing is queued.
    always_comb begin
        rsp_valid = (rsp_count != '0);
        rsp_pop   = rsp_valid && rsp_ready;
        {rsp_result, rsp_carry, rsp_tag} = rsp_valid ? rsp_head : '0;
    end

    // Ready-enable and in-flight tracker registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
            for (int i = 0; i < ALU_LAT; i++) begin
                flight_q[i] <= '0;
            end
        end else begin
            ready_en_q <= ready_en_d;
            for (int i = 0; i < ALU_LAT; i++) begin
                flight_q[i] <= flight_d[i];
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: a behavioural two-cycle ALU drives
// the result inputs, and a transaction-level model predicts issue order and
// responses from accepted commands.
module tb_alu_issue_ctrl;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [3:0] OP_IDLE = 4'd15;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [4:0] sh;
        logic [3:0] tag;
    } cmd_s;

    typedef struct packed {
        logic [7:0] res;
        logic       carry;
        logic [3:0] tag;
    } rsp_s;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid, cmd_ready;
    logic [3:0]       cmd_opcode, cmd_tag;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [4:0]       cmd_shift;
    logic [3:0]       alu_opcode;
    logic [WIDTH-1:0] alu_input1, alu_input2, alu_result;
    logic [4:0]       alu_shiftValue;
    logic             alu_carry;
    logic             rsp_valid, rsp_ready, rsp_carry;
    logic [WIDTH-1:0] rsp_result;
    logic [3:0]       rsp_tag;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    int         acc_cyc [256];
    int         rsp_cyc [256];
    logic [7:0] res_log [256];
    logic       car_log [256];
    logic [3:0] tag_log [256];

    cmd_s iss_q [$];
    rsp_s exp_q [$];
    cmd_s mon_c;
    rsp_s mon_r;

    alu_issue_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_opcode     (cmd_opcode),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .cmd_shift      (cmd_shift),
        .cmd_tag        (cmd_tag),
        .alu_opcode     (alu_opcode),
        .alu_input1     (alu_input1),
        .alu_input2     (alu_input2),
        .alu_shiftValue (alu_shiftValue),
        .alu_result     (alu_result),
        .alu_carry      (alu_carry),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_result     (rsp_result),
        .rsp_carry      (rsp_carry),
        .rsp_tag        (rsp_tag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Raw ALU behaviour {carry, result}; carry is junk (1) for non add/sub ops.
    function automatic logic [8:0] alu_ref(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0]  r;
        logic [15:0] p;
        p = a * b;
        case (op)
            4'd0:    r = {1'b0, a} + {1'b0, b};
            4'd1:    r = {1'b0, a} - {1'b0, b};
            4'd2:    r = {1'b1, p[7:0]};
            4'd3:    r = {1'b1, a | b};
            4'd4:    r = {1'b1, a & b};
            4'd5:    r = {1'b1, a ^ b};
            4'd6:    r = {1'b1, ~(a & b)};
            4'd7:    r = {1'b1, 7'd0, ($signed(a) > $signed(b))};
            default: r = {1'b1, ~(a + b)};
        endcase
        return r;
    endfunction

    function automatic rsp_s expect_rsp(input cmd_s c);
        logic [8:0] raw;
        rsp_s       e;
        raw     = alu_ref(c.op, c.a, c.b);
        e.res   = raw[7:0];
        e.carry = (c.op == 4'd0 || c.op == 4'd1) ? raw[8] : 1'b0;
        e.tag   = c.tag;
        return e;
    endfunction

    // Downstream pipelined ALU: two register stages from operands to result.
    logic [3:0] p1_op = 4'd15, p2_op = 4'd15;
    logic [7:0] p1_a = '0, p1_b = '0, p2_a = '0, p2_b = '0;
    always @(posedge clk) begin
        p1_op <= alu_opcode;
        p1_a  <= alu_input1;
        p1_b  <= alu_input2;
        p2_op <= p1_op;
        p2_a  <= p1_a;
        p2_b  <= p1_b;
    end
    assign {alu_carry, alu_result} = alu_ref(p2_op, p2_a, p2_b);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: reset values, issue order, idle encoding and responses.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            iss_q.delete();
            check("reset_outputs",
                  {cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_tag, alu_opcode, alu_input1, alu_input2, alu_shiftValue},
                  {1'b0, 1'b0, 8'h00, 1'b0, 4'h0, 4'hF, 8'h00, 8'h00, 5'h00});
        end else begin
            if (alu_opcode == OP_IDLE) begin
                check("idle_operands", {alu_input1, alu_input2, alu_shiftValue}, 64'd0);
            end else begin
                check("issue_pending", 64'(iss_q.size() > 0), 64'd1);
                if (iss_q.size() > 0) begin
                    mon_c = iss_q.pop_front();
                    check("issue_fields", {alu_opcode, alu_input1, alu_input2, alu_shiftValue},
                          {mon_c.op, mon_c.a, mon_c.b, mon_c.sh});
                end
            end
            if (rsp_valid) begin
                check("rsp_pending", 64'(exp_q.size() > 0), 64'd1);
                if (rsp_ready && exp_q.size() > 0) begin
                    mon_r = exp_q.pop_front();
                    check("rsp_payload", {rsp_result, rsp_carry, rsp_tag}, {mon_r.res, mon_r.carry, mon_r.tag});
                    res_log[n_rsp] = rsp_result;
                    car_log[n_rsp] = rsp_carry;
                    tag_log[n_rsp] = rsp_tag;
                    rsp_cyc[n_rsp] = cyc;
                    n_rsp++;
                end
            end
            if (cmd_valid && cmd_ready) begin
                mon_c = '{op: cmd_opcode, a: cmd_a, b: cmd_b, sh: cmd_shift, tag: cmd_tag};
                iss_q.push_back(mon_c);
                exp_q.push_back(expect_rsp(mon_c));
                acc_cyc[n_acc] = cyc;
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [4:0] sh, input logic [3:0] tag);
        bit got = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_shift  = sh;
        cmd_tag    = tag;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = cmd_ready;
            tick();
        end
        check("send_accepted", 64'(got), 64'd1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int target, input int budget);
        int k = 0;
        while (n_rsp < target && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(n_rsp >= target), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ir, ia, accepted, snap;
        bit  got;
        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_opcode = '0;
        cmd_a      = '0;
        cmd_b      = '0;
        cmd_shift  = '0;
        cmd_tag    = '0;
        rsp_ready  = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_in_release_cycle", 64'(cmd_ready), 64'd0);
        @(negedge clk);
        check("ready_after_release", 64'(cmd_ready), 64'd1);
        tick();

        // ADD with carry out and the minimum accept-to-response latency.
        ir = n_rsp; ia = n_acc;
        send(4'd0, 8'hF0, 8'h20, 5'd0, 4'd3);
        wait_rsp("wait_add", ir + 1, 20);
        check("add_result", res_log[ir], 64'h10);
        check("add_carry", car_log[ir], 64'd1);
        check("add_tag", tag_log[ir], 64'd3);
        check("add_latency", 64'(rsp_cyc[ir] - acc_cyc[ia]), 64'd4);

        // SUB with borrow followed by AND with carry suppressed.
        ir = n_rsp;
        send(4'd1, 8'h05, 8'h07, 5'd2, 4'd1);
        send(4'd4, 8'hFF, 8'h0F, 5'd3, 4'd2);
        wait_rsp("wait_sub_and", ir + 2, 20);
        check("sub_result", res_log[ir], 64'hFE);
        check("sub_carry", car_log[ir], 64'd1);
        check("and_result", res_log[ir+1], 64'h0F);
        check("and_carry", car_log[ir+1], 64'd0);
        check("sub_and_order", {tag_log[ir], tag_log[ir+1]}, {4'd1, 4'd2});

        // MUL truncation, signed compare and an undefined opcode.
        ir = n_rsp;
        send(4'd2, 8'h10, 8'h11, 5'd0, 4'd6);
        send(4'd7, 8'h80, 8'h01, 5'd0, 4'd7);
        send(4'd7, 8'h05, 8'hFF, 5'd0, 4'd8);
        send(4'd9, 8'h3C, 8'h0F, 5'd31, 4'd9);
        wait_rsp("wait_misc", ir + 4, 30);
        check("mul_result", res_log[ir], 64'h10);
        check("mul_carry", car_log[ir], 64'd0);
        check("sgt_neg", res_log[ir+1], 64'h00);
        check("sgt_pos", res_log[ir+2], 64'h01);
        check("undef_result", res_log[ir+3], 64'hB4);

        // Backpressure: responses stalled, commands offered back to back.
        rsp_ready = 1'b0;
        ir = n_rsp;
        accepted = 0;
        for (int i = 0; i < 30 && accepted < 10; i++) begin
            cmd_valid  = 1'b1;
            cmd_opcode = 4'(accepted % 7);
            cmd_a      = 8'(accepted * 17);
            cmd_b      = 8'(accepted + 1);
            cmd_shift  = 5'(accepted);
            cmd_tag    = 4'(accepted);
            @(negedge clk);
            got = cmd_ready;
            tick();
            if (got) accepted++;
        end
        cmd_valid = 1'b0;
        check("bp_accepted", 64'(accepted), 64'(2 * DEPTH));
        @(negedge clk);
        check("bp_ready_low", 64'(cmd_ready), 64'd0);
        check("bp_alu_idle", 64'(alu_opcode), 64'hF);
        tick();
        rsp_ready = 1'b1;
        wait_rsp("wait_drain", ir + 2 * DEPTH, 60);
        for (int i = 0; i < 2 * DEPTH; i++) begin
            check("drain_order", tag_log[ir+i], 64'(i));
        end

        // Reset with three commands queued or in flight.
        send(4'd0, 8'h01, 8'h01, 5'd0, 4'hA);
        send(4'd0, 8'h02, 8'h02, 5'd0, 4'hB);
        send(4'd0, 8'h03, 8'h03, 5'd0, 4'hC);
        rst_n = 1'b0;
        snap  = n_rsp;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("no_rsp_after_reset", 64'(n_rsp), 64'(snap));
        ir = n_rsp;
        send(4'd0, 8'h01, 8'h02, 5'd0, 4'h5);
        wait_rsp("wait_post_reset", ir + 1, 20);
        check("post_reset_rsp", {res_log[ir], car_log[ir], tag_log[ir]}, {8'h03, 1'b0, 4'h5});

        // Continuous streaming with tag wrap.
        ir = n_rsp;
        for (int i = 0; i < 20; i++) begin
            send(4'(i % 15), 8'(i * 7), 8'(i * 3 + 1), 5'(i), 4'(i));
        end
        wait_rsp("wait_stream", ir + 20, 40);
        check("stream_rate", 64'(rsp_cyc[ir+19] - rsp_cyc[ir]), 64'd19);
        for (int i = 0; i < 20; i++) begin
            check("stream_tag", tag_log[ir+i], 64'(i % 16));
        end

        repeat (5) tick();
        check("model_drained", 64'(exp_q.size() + iss_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of operands and results.
REQ-002 Parameter DEPTH, default 4, entries in each of the command and response FIFOs (power of two, >=2).
REQ-003 clk  in  1  single clock, all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  upstream command handshake.
REQ-006 cmd_opcode  in  4  ALU opcode (0 ADD, 1 SUB, 2 MUL, 3 OR, 4 AND, 5 XOR, 6 NAND, 7 SGT).
REQ-007 cmd_a, cmd_b  in  WIDTH  operands.
REQ-008 cmd_shift  in  5  shift amount, passed through.
REQ-009 cmd_tag  in  4  opaque command tag.
REQ-010 alu_opcode, alu_input1, alu_input2, alu_shiftValue  out  4/WIDTH/WIDTH/5  drive the downstream pipelined ALU.
REQ-011 alu_result  in  WIDTH, alu_carry  in  1  ALU outputs.
REQ-012 rsp_valid/rsp_ready  out/in  1/1  downstream response handshake.
REQ-013 rsp_result  out  WIDTH, rsp_carry  out  1, rsp_tag  out  4  response payload.

Function
REQ-014 Command accepted on clk edge when cmd_valid && cmd_ready; payload written to command FIFO.
REQ-015 cmd_ready SHALL be 1 iff command FIFO not full; no combinational path cmd_valid->cmd_ready.
REQ-016 Issue: at most one command per cycle; head of command FIFO issued when FIFO non-empty and credit available (REQ-019).
REQ-017 Issued command: alu_* outputs driven from FIFO head combinationally in issue cycle t; ALU result sampled from alu_result/alu_carry in cycle t+2 (fixed latency 2).
REQ-018 Idle cycles: alu_opcode SHALL be 4'd15, alu_input1/alu_input2/alu_shiftValue SHALL be 0.
REQ-019 Credit: issue only if (response FIFO occupancy + in-flight count) < DEPTH; response FIFO never overflows, ALU never stalled.
REQ-020 In-flight tracking: 2-stage valid/tag/opcode shift register; stage-2 valid writes {alu_result, carry, tag} into response FIFO.
REQ-021 rsp_carry SHALL equal alu_carry for opcodes ADD/SUB, 0 for all others (ALU carry is stale for other ops).
REQ-022 rsp_valid = response FIFO non-empty; payload from head; pop on rsp_valid && rsp_ready.
REQ-023 Simultaneous push/pop on either FIFO when full or empty SHALL both take effect (pass-through of occupancy unchanged; empty-FIFO bypass not permitted, min latency accept->rsp_valid = 4 cycles).
REQ-024 Order preserved: responses leave in acceptance order; pointers wrap modulo DEPTH.
REQ-025 Opcode 7 (SGT) and undefined opcodes 8..15 accepted and issued unchanged; response reports whatever alu_result returns.

Reset
REQ-026 While rst_n=0: both FIFOs empty, in-flight valids 0, pointers/counters 0.
REQ-027 Outputs under reset: cmd_ready=0, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_tag=0, alu_opcode=4'd15, other alu_* = 0.
REQ-028 cmd_ready SHALL rise in first cycle after rst_n deasserts.
REQ-029 Reset mid-operation discards all queued and in-flight commands; no response emitted for them after release.

Structure
REQ-030 Shared package alu_pkg holds opcode constants (ADD..SGT, OP_IDLE=4'd15) and latency constant ALU_LAT=2.
REQ-031 One sub-module alu_sync_fifo (parameterised width/depth, count output) instantiated twice (command, response).
REQ-032 Block not containing the ALU; top level connects alu_* ports and inverts reset for the ALU.

Verification
REQ-033 ADD a=8'hF0 b=8'h20 tag=3, rsp_ready=1 -> rsp_result=8'h10, rsp_carry=1, rsp_tag=3, rsp_valid 4 cycles after accept.
REQ-034 SUB 8'h05-8'h07 then AND 8'hFF&8'h0F -> responses 8'hFE carry=1, then 8'h0F carry=0, in order.
REQ-035 rsp_ready=0, 10 back-to-back commands -> exactly DEPTH*2 accepted, cmd_ready=0 thereafter, alu_opcode=15 once credit exhausted; release rsp_ready -> all 8 drain in order, no loss.
REQ-036 MUL 8'h10*8'h11 -> rsp_result=8'h10, rsp_carry=0.
REQ-037 rst_n pulsed low with 3 commands in flight -> all outputs at reset values, no responses after release, new command completes normally.
REQ-038 Continuous streaming with rsp_ready=1 -> one response per cycle steady state, tags increment 0..15 with wrap.
